// File: rtl/qspi_arb_pkg.sv
// Shared definitions for the QSPI bus arbiter: slot indices, FSM states,
// error-flag bit positions and the captured per-slot request attributes.
package qspi_arb_pkg;

  localparam int unsigned NUM_SLOTS = 5;

  typedef logic [NUM_SLOTS-1:0] slot_vec_t;
  typedef logic [2:0]           slot_idx_t;

  localparam slot_idx_t SLOT_I_RD = 3'd0;
  localparam slot_idx_t SLOT_D_RD = 3'd1;
  localparam slot_idx_t SLOT_D_WR = 3'd2;
  localparam slot_idx_t SLOT_U_RD = 3'd3;
  localparam slot_idx_t SLOT_U_WR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam int unsigned ERR_OVF   = 0;
  localparam int unsigned ERR_TMO   = 1;
  localparam int unsigned ERR_STRAY = 2;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
    logic        w;
    logic        hw;
  } slot_attr_t;

  function automatic logic is_write_slot(input slot_idx_t idx);
    return (idx == SLOT_D_WR) || (idx == SLOT_U_WR);
  endfunction

endpackage

// File: rtl/qspi_bus_arbiter_if.sv
// Request/completion bundle between the requesters (cpu_top, uart_top),
// the arbiter and qspi_if.
//   slave  : arbiter view (requests and qspi_if completions in, bus and
//            per-source completions out)
//   master : environment view (drives requests/completions, observes bus)
interface qspi_bus_arbiter_if;
  logic        i_read_req, i_read_w, i_read_hw;
  logic [31:0] i_read_adr;
  logic        d_read_req, d_read_w, d_read_hw;
  logic [31:0] d_read_adr;
  logic        d_write_req, d_write_w, d_write_hw;
  logic [31:0] d_write_adr, d_write_data;
  logic        u_read_req, u_read_w;
  logic [31:0] u_read_adr;
  logic        u_write_req, u_write_w;
  logic [31:0] u_write_adr, u_write_data;

  logic        read_req, read_w, read_hw;
  logic [31:0] read_adr;
  logic        write_req, write_w, write_hw;
  logic [31:0] write_adr, write_data;

  logic        read_valid, write_finish;

  logic        i_read_valid, d_read_valid, u_read_valid;
  logic        d_write_finish, u_write_finish;
  logic        bus_timeout;
  logic [2:0]  err_flags;
  logic        err_clr;

  modport slave (
    input  i_read_req, i_read_w, i_read_hw, i_read_adr,
    input  d_read_req, d_read_w, d_read_hw, d_read_adr,
    input  d_write_req, d_write_w, d_write_hw, d_write_adr, d_write_data,
    input  u_read_req, u_read_w, u_read_adr,
    input  u_write_req, u_write_w, u_write_adr, u_write_data,
    input  read_valid, write_finish, err_clr,
    output read_req, read_w, read_hw, read_adr,
    output write_req, write_w, write_hw, write_adr, write_data,
    output i_read_valid, d_read_valid, u_read_valid,
    output d_write_finish, u_write_finish, bus_timeout, err_flags
  );

  modport master (
    output i_read_req, i_read_w, i_read_hw, i_read_adr,
    output d_read_req, d_read_w, d_read_hw, d_read_adr,
    output d_write_req, d_write_w, d_write_hw, d_write_adr, d_write_data,
    output u_read_req, u_read_w, u_read_adr,
    output u_write_req, u_write_w, u_write_adr, u_write_data,
    output read_valid, write_finish, err_clr,
    input  read_req, read_w, read_hw, read_adr,
    input  write_req, write_w, write_hw, write_adr, write_data,
    input  i_read_valid, d_read_valid, u_read_valid,
    input  d_write_finish, u_write_finish, bus_timeout, err_flags
  );
endinterface

// File: rtl/qspi_arb_pick.sv
// Combinational winner selection among pending slots.
//   pend_i     : pending bit per slot
//   prefer_d_i : 1 = d_read wins a d_read/i_read tie, 0 = i_read wins
//   grant_o    : one-hot winner
//   valid_o    : any slot pending
module qspi_arb_pick
  import qspi_arb_pkg::*;
(
  input  slot_vec_t pend_i,
  input  logic      prefer_d_i,
  output slot_vec_t grant_o,
  output logic      valid_o
);

  always_comb begin
    grant_o = '0;
    if (pend_i[SLOT_U_WR]) begin
      grant_o[SLOT_U_WR] = 1'b1;
    end else if (pend_i[SLOT_U_RD]) begin
      grant_o[SLOT_U_RD] = 1'b1;
    end else if (pend_i[SLOT_D_WR]) begin
      grant_o[SLOT_D_WR] = 1'b1;
    end else if (pend_i[SLOT_D_RD] && pend_i[SLOT_I_RD]) begin
      if (prefer_d_i) grant_o[SLOT_D_RD] = 1'b1;
      else            grant_o[SLOT_I_RD] = 1'b1;
    end else if (pend_i[SLOT_D_RD]) begin
      grant_o[SLOT_D_RD] = 1'b1;
    end else if (pend_i[SLOT_I_RD]) begin
      grant_o[SLOT_I_RD] = 1'b1;
    end
  end

  assign valid_o = |pend_i;

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Single-owner arbiter for the QSPI memory port. Five request sources each
// own one slot (pending bit + captured attributes); one transaction is
// issued at a time and its completion is routed back to the owner, with a
// forced completion if memory never answers.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request, qspi_if bus, completion and error signals (slave)
//   TIMEOUT_CYC : WAIT cycles before forced completion (2..65535)
module qspi_bus_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input logic               clk,
  input logic               rst,
  qspi_bus_arbiter_if.slave bus
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  arb_state_e  state_q;
  slot_idx_t   owner_q;
  // Round-robin pointer between d_read and i_read kept as "d_read wins the
  // next tie"; set after an i_read grant, cleared after a d_read grant.
  logic        prefer_d_q;
  logic [15:0] tmo_cnt_q;
  slot_vec_t   pend_q, pend_d;
  slot_attr_t  slot_q [NUM_SLOTS];
  logic [2:0]  err_q, err_d;

  logic        rd_req_q, rd_w_q, rd_hw_q;
  logic [31:0] rd_adr_q;
  logic        wr_req_q, wr_w_q, wr_hw_q;
  logic [31:0] wr_adr_q, wr_data_q;

  slot_vec_t   req_v, busy, accept, grant, done_vec;
  slot_attr_t  req_attr [NUM_SLOTS];
  slot_idx_t   pick_idx;
  logic        pick_valid, in_wait, owner_wr, match, tmo, done, stray, ovf;
  logic [2:0]  err_set;

  always_comb begin
    req_v = '0;
    req_v[SLOT_I_RD] = bus.i_read_req;
    req_v[SLOT_D_RD] = bus.d_read_req;
    req_v[SLOT_D_WR] = bus.d_write_req;
    req_v[SLOT_U_RD] = bus.u_read_req;
    req_v[SLOT_U_WR] = bus.u_write_req;
    req_attr[SLOT_I_RD] = '{adr: bus.i_read_adr,  data: '0,
                            w: bus.i_read_w,  hw: bus.i_read_hw};
    req_attr[SLOT_D_RD] = '{adr: bus.d_read_adr,  data: '0,
                            w: bus.d_read_w,  hw: bus.d_read_hw};
    req_attr[SLOT_D_WR] = '{adr: bus.d_write_adr, data: bus.d_write_data,
                            w: bus.d_write_w, hw: bus.d_write_hw};
    req_attr[SLOT_U_RD] = '{adr: bus.u_read_adr,  data: '0,
                            w: bus.u_read_w,  hw: 1'b0};
    req_attr[SLOT_U_WR] = '{adr: bus.u_write_adr, data: bus.u_write_data,
                            w: bus.u_write_w, hw: 1'b0};
  end

  qspi_arb_pick u_pick (
    .pend_i     (pend_q),
    .prefer_d_i (prefer_d_q),
    .grant_o    (grant),
    .valid_o    (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (grant[s]) pick_idx = slot_idx_t'(s);
    end
  end

  always_comb begin
    in_wait  = (state_q == ST_WAIT);
    owner_wr = is_write_slot(owner_q);
    match    = in_wait && (owner_wr ? bus.write_finish : bus.read_valid);
    // A real completion in the last WAIT cycle wins over the forced one.
    tmo      = in_wait && !match && (tmo_cnt_q == TMO_LAST);
    done     = match || tmo;
    done_vec = done ? (slot_vec_t'(1) << owner_q) : '0;
    stray    = in_wait ? (owner_wr ? bus.read_valid : bus.write_finish)
                       : (bus.read_valid || bus.write_finish);

    // The owner counts as busy until its completion cycle, so a request in
    // that same cycle is accepted.
    busy = pend_q;
    if (state_q != ST_IDLE) busy = busy | (slot_vec_t'(1) << owner_q);
    busy   = busy & ~done_vec;
    accept = req_v & ~busy;
    ovf    = |(req_v & busy);

    err_set            = '0;
    err_set[ERR_OVF]   = ovf;
    err_set[ERR_TMO]   = tmo;
    err_set[ERR_STRAY] = stray;
    err_d = bus.err_clr ? '0 : (err_q | err_set);

    pend_d = pend_q;
    if (state_q == ST_IDLE) pend_d = pend_d & ~grant;
    pend_d = pend_d | accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      prefer_d_q <= 1'b1;
      tmo_cnt_q  <= '0;
      pend_q     <= '0;
      err_q      <= '0;
      rd_req_q   <= 1'b0;
      rd_w_q     <= 1'b0;
      rd_hw_q    <= 1'b0;
      rd_adr_q   <= '0;
      wr_req_q   <= 1'b0;
      wr_w_q     <= 1'b0;
      wr_hw_q    <= 1'b0;
      wr_adr_q   <= '0;
      wr_data_q  <= '0;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) slot_q[s] <= '0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (accept[s]) slot_q[s] <= req_attr[s];
      end

      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_ISSUE;
            owner_q <= pick_idx;
            if (grant[SLOT_D_RD])      prefer_d_q <= 1'b0;
            else if (grant[SLOT_I_RD]) prefer_d_q <= 1'b1;
            if (is_write_slot(pick_idx)) begin
              wr_req_q  <= 1'b1;
              wr_adr_q  <= slot_q[pick_idx].adr;
              wr_data_q <= slot_q[pick_idx].data;
              wr_w_q    <= slot_q[pick_idx].w;
              wr_hw_q   <= slot_q[pick_idx].hw;
            end else begin
              rd_req_q  <= 1'b1;
              rd_adr_q  <= slot_q[pick_idx].adr;
              rd_w_q    <= slot_q[pick_idx].w;
              rd_hw_q   <= slot_q[pick_idx].hw;
            end
          end
        end
        ST_ISSUE: begin
          rd_req_q  <= 1'b0;
          wr_req_q  <= 1'b0;
          tmo_cnt_q <= '0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            state_q   <= ST_IDLE;
            rd_w_q    <= 1'b0;
            rd_hw_q   <= 1'b0;
            rd_adr_q  <= '0;
            wr_w_q    <= 1'b0;
            wr_hw_q   <= 1'b0;
            wr_adr_q  <= '0;
            wr_data_q <= '0;
          end else if (tmo_cnt_q != '1) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.read_req       = rd_req_q;
  assign bus.read_w         = rd_w_q;
  assign bus.read_hw        = rd_hw_q;
  assign bus.read_adr       = rd_adr_q;
  assign bus.write_req      = wr_req_q;
  assign bus.write_w        = wr_w_q;
  assign bus.write_hw       = wr_hw_q;
  assign bus.write_adr      = wr_adr_q;
  assign bus.write_data     = wr_data_q;
  assign bus.i_read_valid   = done_vec[SLOT_I_RD];
  assign bus.d_read_valid   = done_vec[SLOT_D_RD];
  assign bus.d_write_finish = done_vec[SLOT_D_WR];
  assign bus.u_read_valid   = done_vec[SLOT_U_RD];
  assign bus.u_write_finish = done_vec[SLOT_U_WR];
  assign bus.bus_timeout    = tmo;
  assign bus.err_flags      = err_q;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Self-checking bench for qspi_bus_arbiter: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// transaction-level model of the arbitration rules.
module tb_qspi_bus_arbiter;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qspi_bus_arbiter_if bus();
  qspi_bus_arbiter #(.TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // slots: 0 i_read, 1 d_read, 2 d_write, 3 u_read, 4 u_write
  bit          m_pend [5];
  logic [31:0] m_adr [5], m_dat [5];
  bit          m_w [5], m_hw [5];
  int          m_own, m_phase, m_wait_n;   // phase 0 idle, 1 issue, 2 wait
  bit          m_prefer_d;
  logic [2:0]  m_err;
  logic [31:0] o_adr, o_dat;
  bit          o_w, o_hw;

  // memory responder / stimulus control
  bit auto_mem = 1'b1;
  bit rnd_mem  = 1'b0;
  bit rr_mode  = 1'b0;
  int fixed_lat = 2;
  int lat_target;

  // observation logs
  int n_rd_issue, n_wr_issue;
  int n_valid [5];
  logic [63:0] iss_log [$];
  int grant_log [$];

  function automatic bit is_wr(input int s);
    return (s == 2) || (s == 4);
  endfunction

  function automatic int winner();
    if (m_pend[4]) return 4;
    if (m_pend[3]) return 3;
    if (m_pend[2]) return 2;
    if (m_pend[1] && m_pend[0]) return m_prefer_d ? 1 : 0;
    if (m_pend[1]) return 1;
    if (m_pend[0]) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 5; s++) begin
      m_pend[s] = 0; m_adr[s] = '0; m_dat[s] = '0; m_w[s] = 0; m_hw[s] = 0;
    end
    m_own = -1; m_phase = 0; m_wait_n = 0; m_prefer_d = 1; m_err = '0;
    o_adr = '0; o_dat = '0; o_w = 0; o_hw = 0;
  endtask

  task automatic clear_logs();
    n_rd_issue = 0; n_wr_issue = 0;
    for (int s = 0; s < 5; s++) n_valid[s] = 0;
    iss_log.delete();
    grant_log.delete();
  endtask

  task automatic get_req(input int s, output bit r, output logic [31:0] a,
                         output logic [31:0] d, output bit w, output bit hw);
    case (s)
      0: begin r = bus.i_read_req;  a = bus.i_read_adr;  d = '0; w = bus.i_read_w;  hw = bus.i_read_hw; end
      1: begin r = bus.d_read_req;  a = bus.d_read_adr;  d = '0; w = bus.d_read_w;  hw = bus.d_read_hw; end
      2: begin r = bus.d_write_req; a = bus.d_write_adr; d = bus.d_write_data; w = bus.d_write_w; hw = bus.d_write_hw; end
      3: begin r = bus.u_read_req;  a = bus.u_read_adr;  d = '0; w = bus.u_read_w;  hw = 0; end
      default: begin r = bus.u_write_req; a = bus.u_write_adr; d = bus.u_write_data; w = bus.u_write_w; hw = 0; end
    endcase
  endtask

  task automatic pulse(input int s, input logic [31:0] a, input logic [31:0] d,
                       input bit w, input bit hw);
    case (s)
      0: begin bus.i_read_req = 1; bus.i_read_adr = a; bus.i_read_w = w; bus.i_read_hw = hw; end
      1: begin bus.d_read_req = 1; bus.d_read_adr = a; bus.d_read_w = w; bus.d_read_hw = hw; end
      2: begin bus.d_write_req = 1; bus.d_write_adr = a; bus.d_write_data = d;
               bus.d_write_w = w; bus.d_write_hw = hw; end
      3: begin bus.u_read_req = 1; bus.u_read_adr = a; bus.u_read_w = w; end
      default: begin bus.u_write_req = 1; bus.u_write_adr = a; bus.u_write_data = d; bus.u_write_w = w; end
    endcase
  endtask

  task automatic clear_pulses();
    bus.i_read_req = 0; bus.d_read_req = 0; bus.d_write_req = 0;
    bus.u_read_req = 0; bus.u_write_req = 0;
    bus.read_valid = 0; bus.write_finish = 0; bus.err_clr = 0;
  endtask

  task automatic clear_all();
    clear_pulses();
    bus.i_read_w = 0; bus.i_read_hw = 0; bus.i_read_adr = '0;
    bus.d_read_w = 0; bus.d_read_hw = 0; bus.d_read_adr = '0;
    bus.d_write_w = 0; bus.d_write_hw = 0; bus.d_write_adr = '0; bus.d_write_data = '0;
    bus.u_read_w = 0; bus.u_read_adr = '0;
    bus.u_write_w = 0; bus.u_write_adr = '0; bus.u_write_data = '0;
  endtask

  // Evaluate one cycle: respond as memory, compare outputs, advance model.
  task automatic settle();
    bit iw, rv, wf, match, tmo, done, stray, ovf, busy, r;
    bit acc [5];
    logic [31:0] ra [5], rd [5];
    bit rw [5], rhw [5];
    logic [4:0] dvec;
    logic [71:0] e_rd, e_wr, e_cmp;
    int w;

    if (auto_mem && !rst && m_phase == 2 && lat_target != 0 && m_wait_n == lat_target) begin
      if (is_wr(m_own)) bus.write_finish = 1; else bus.read_valid = 1;
      if (rr_mode) pulse(m_own, (m_own == 1) ? 32'h1000 : 32'h0800, '0, 0, 0);
    end
    #1;
    rv = bus.read_valid; wf = bus.write_finish;
    iw    = (m_phase != 0) && is_wr(m_own);
    match = (m_phase == 2) && (iw ? wf : rv);
    tmo   = (m_phase == 2) && !match && (m_wait_n == TMO);
    done  = match || tmo;
    dvec = '0;
    if (done) dvec[m_own] = 1'b1;
    e_rd = '0; e_wr = '0;
    if (m_phase != 0 && !iw) e_rd = {(m_phase == 1), o_w, o_hw, o_adr};
    if (m_phase != 0 && iw)  e_wr = {(m_phase == 1), o_w, o_hw, o_adr, o_dat};
    e_cmp = {tmo, dvec};
    if (rst) begin e_rd = '0; e_wr = '0; e_cmp = '0; end

    chk("rd_bus", {bus.read_req, bus.read_w, bus.read_hw, bus.read_adr}, e_rd);
    chk("wr_bus", {bus.write_req, bus.write_w, bus.write_hw, bus.write_adr, bus.write_data}, e_wr);
    chk("completion", {bus.bus_timeout, bus.u_write_finish, bus.u_read_valid,
                       bus.d_write_finish, bus.d_read_valid, bus.i_read_valid}, e_cmp);
    chk("err_flags", bus.err_flags, rst ? 3'b000 : m_err);

    n_rd_issue += bus.read_req;
    n_wr_issue += bus.write_req;
    n_valid[0] += bus.i_read_valid;  n_valid[1] += bus.d_read_valid;
    n_valid[2] += bus.d_write_finish; n_valid[3] += bus.u_read_valid;
    n_valid[4] += bus.u_write_finish;
    if (bus.read_req)  iss_log.push_back({bus.read_adr, 32'h0});
    if (bus.write_req) iss_log.push_back({bus.write_adr, bus.write_data});

    if (rst) begin
      model_reset();
      return;
    end

    stray = (m_phase != 2) ? (rv || wf) : (iw ? rv : wf);
    ovf = 0;
    for (int s = 0; s < 5; s++) begin
      get_req(s, r, ra[s], rd[s], rw[s], rhw[s]);
      busy = m_pend[s] || (m_phase != 0 && m_own == s && !done);
      acc[s] = r && !busy;
      if (r && busy) ovf = 1;
    end
    m_err = bus.err_clr ? 3'b000 : (m_err | {stray, tmo, ovf});

    case (m_phase)
      0: begin
        w = winner();
        if (w >= 0) begin
          m_own = w; m_pend[w] = 0; m_phase = 1;
          o_adr = m_adr[w]; o_dat = m_dat[w]; o_w = m_w[w]; o_hw = m_hw[w];
          if (w == 1) m_prefer_d = 0;
          else if (w == 0) m_prefer_d = 1;
          grant_log.push_back(w);
          if (rnd_mem) lat_target = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
          else lat_target = fixed_lat;
        end
      end
      1: begin m_phase = 2; m_wait_n = 1; end
      default: begin
        if (done) begin m_phase = 0; m_own = -1; end
        else m_wait_n++;
      end
    endcase

    for (int s = 0; s < 5; s++) begin
      if (acc[s]) begin
        m_pend[s] = 1; m_adr[s] = ra[s]; m_dat[s] = rd[s]; m_w[s] = rw[s]; m_hw[s] = rhw[s];
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    clear_pulses();
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    rst = 1;
    clear_pulses();
    step();
    step();
    rst = 0;
    clear_logs();
  endtask

  int k_hit, k_hit2;

  initial begin
    rst = 1;
    clear_all();
    model_reset();
    clear_logs();
    @(posedge clk);
    #1;

    // ---- reset state ----
    do_reset();
    settle();
    chk("reset_err", bus.err_flags, 3'b000);
    chk("reset_reqs", {bus.read_req, bus.write_req}, 2'b00);
    advance();

    // ---- single read, memory answers 5 cycles after read_req ----
    do_reset();
    auto_mem = 1; rnd_mem = 0; fixed_lat = 5;
    k_hit = -1; k_hit2 = -1;
    for (int k = 0; k < 14; k++) begin
      if (k == 0) pulse(0, 32'h0000_0100, '0, 0, 0);
      settle();
      if (bus.read_req && k_hit < 0) begin
        k_hit = k;
        chk("sr_adr", bus.read_adr, 32'h100);
      end
      if (bus.i_read_valid) k_hit2 = k;
      advance();
    end
    chk("sr_issue_cyc", k_hit, 2);
    chk("sr_valid_cyc", k_hit2, 7);
    chk("sr_valid_cnt", n_valid[0], 1);
    chk("sr_other_cnt", n_valid[1] + n_valid[2] + n_valid[3] + n_valid[4], 0);

    // ---- fixed priority ----
    do_reset();
    fixed_lat = 2;
    pulse(4, 32'h4000, 32'hAAAA_0004, 0, 0);
    pulse(2, 32'h2000, 32'hBBBB_0002, 1, 0);
    pulse(1, 32'h1000, '0, 0, 1);
    pulse(0, 32'h0800, '0, 1, 0);
    for (int k = 0; k < 60 && iss_log.size() < 4; k++) step();
    chk("prio_count", iss_log.size(), 4);
    if (iss_log.size() == 4) begin
      chk("prio_0", iss_log[0], {32'h4000, 32'hAAAA_0004});
      chk("prio_1", iss_log[1], {32'h2000, 32'hBBBB_0002});
      chk("prio_2", iss_log[2], {32'h1000, 32'h0});
      chk("prio_3", iss_log[3], {32'h0800, 32'h0});
    end
    for (int k = 0; k < 10; k++) step();

    // ---- round-robin d_read / i_read ----
    do_reset();
    rr_mode = 1;
    pulse(1, 32'h1000, '0, 0, 0);
    pulse(0, 32'h0800, '0, 0, 0);
    for (int k = 0; k < 150 && iss_log.size() < 6; k++) step();
    rr_mode = 0;
    chk("rr_count", iss_log.size(), 6);
    for (int i = 0; i < iss_log.size() && i < 6; i++)
      chk("rr_order", iss_log[i][63:32], (i % 2 == 0) ? 32'h1000 : 32'h0800);

    // ---- timeout ----
    do_reset();
    fixed_lat = 0;
    k_hit = -1;
    for (int k = 0; k < 14; k++) begin
      if (k == 0) pulse(2, 32'h3000, 32'h0000_0055, 0, 0);
      settle();
      if (bus.bus_timeout && bus.d_write_finish) k_hit = k;
      advance();
    end
    chk("tmo_cyc", k_hit, 10);
    settle();
    chk("tmo_err", bus.err_flags, 3'b010);
    advance();
    bus.write_finish = 1;
    step();
    settle();
    chk("tmo_stray_err", bus.err_flags, 3'b110);
    advance();
    bus.err_clr = 1;
    step();
    settle();
    chk("tmo_clr_err", bus.err_flags, 3'b000);
    advance();

    // ---- overflow ----
    do_reset();
    fixed_lat = 4;
    for (int k = 0; k < 20; k++) begin
      if (k == 0) pulse(3, 32'h7000, '0, 0, 0);
      if (k == 3) pulse(3, 32'h7100, '0, 0, 0);
      step();
    end
    chk("ovf_issues", n_rd_issue, 1);
    chk("ovf_valid", n_valid[3], 1);
    settle();
    chk("ovf_err", bus.err_flags, 3'b001);
    advance();

    // ---- reset during WAIT with two slots pending ----
    do_reset();
    fixed_lat = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) pulse(4, 32'h9000, 32'h1234_5678, 1, 0);
      if (k == 4) begin pulse(1, 32'h1100, '0, 0, 0); pulse(0, 32'h0900, '0, 0, 0); end
      step();
    end
    rst = 1;
    settle();
    chk("mrst_outs", {bus.read_req, bus.write_req, bus.write_adr, bus.write_data,
                      bus.u_write_finish, bus.bus_timeout, bus.err_flags}, '0);
    advance();
    step();
    rst = 0;
    clear_logs();
    for (int k = 0; k < 10; k++) step();
    chk("mrst_no_issue", n_rd_issue + n_wr_issue, 0);
    bus.write_finish = 1;
    step();
    settle();
    chk("mrst_stray", bus.err_flags, 3'b100);
    advance();

    // ---- randomized traffic ----
    do_reset();
    rnd_mem = 1;
    for (int k = 0; k < 3000; k++) begin
      for (int s = 0; s < 5; s++)
        if ($urandom_range(0, 5) == 0)
          pulse(s, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) bus.read_valid = 1;
      if ($urandom_range(0, 39) == 0) bus.write_finish = 1;
      if ($urandom_range(0, 59) == 0) bus.err_clr = 1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

endmodule
